fft_r22sdf_reorder: RTL and testbench

//   Ping-pong reorder buffer directly downstream of the R2^2 SDF FFT core. The core emits bins in
//   bit-reversed order with a per-sample bin index and a sticky sync. This block stores each frame
//   by bin index and replays it in natural order (bin 0..N-1) to a consumer with ready/valid

---
 rtl/fft_r22sdf_reorder_pkg.sv | 27 ++
 rtl/fft_r22sdf_reorder_bank.sv | 48 ++++
 rtl/fft_r22sdf_reorder.sv | 198 +++++++++++++++++++
 tb/tb_fft_r22sdf_reorder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_r22sdf_reorder_pkg.sv
// Shared types for the R2^2 SDF output reorder buffer: default FFT geometry,
// per-bank occupancy states and the writer/reader state encodings.
package fft_r22sdf_reorder_pkg;

    localparam int FFT_N          = 1024;
    localparam int FFT_N_LOG2     = 10;
    localparam int FFT_DATA_WIDTH = 25;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_st_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DROP = 2'd2
    } wr_st_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_st_t;

endpackage

// File: rtl/fft_r22sdf_reorder_bank.sv
// One reorder bank: re/im sample RAM pair, one write and one registered read port.
// Read data appears one cycle after i_re and holds while i_re is low.
module fft_r22sdf_reorder_bank
    import fft_r22sdf_reorder_pkg::*;
#(
    parameter int N          = FFT_N,
    parameter int N_LOG2     = FFT_N_LOG2,
    parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         i_we,
    input  logic [N_LOG2-1:0]            i_waddr,
    input  logic signed [DATA_WIDTH-1:0] i_wre,
    input  logic signed [DATA_WIDTH-1:0] i_wim,
    input  logic                         i_re,
    input  logic [N_LOG2-1:0]            i_raddr,
    output logic signed [DATA_WIDTH-1:0] o_re,
    output logic signed [DATA_WIDTH-1:0] o_im
);

    logic signed [DATA_WIDTH-1:0] r_mem_re [N];
    logic signed [DATA_WIDTH-1:0] r_mem_im [N];
    logic signed [DATA_WIDTH-1:0] r_rd_re;
    logic signed [DATA_WIDTH-1:0] r_rd_im;

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem_re[i_waddr] <= i_wre;
            r_mem_im[i_waddr] <= i_wim;
        end
    end

    // Read-first: a same-cycle write to the same address returns the old sample.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_rd_re <= '0;
            r_rd_im <= '0;
        end else if (i_re) begin
            r_rd_re <= r_mem_re[i_raddr];
            r_rd_im <= r_mem_im[i_raddr];
        end
    end

    assign o_re = r_rd_re;
    assign o_im = r_rd_im;

endmodule

// File: rtl/fft_r22sdf_reorder.sv
// Ping-pong reorder of bit-reversed FFT bins into natural order; 2 cycles from last write to bin 0.
// Output holds while valid_o && !ready_i; frames arriving with no free bank are dropped.
module fft_r22sdf_reorder
    import fft_r22sdf_reorder_pkg::*;
#(
    parameter int N          = FFT_N,
    parameter int N_LOG2     = FFT_N_LOG2,
    parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         sync_i,
    input  logic [N_LOG2-1:0]            bin_i,
    input  logic signed [DATA_WIDTH-1:0] data_re_i,
    input  logic signed [DATA_WIDTH-1:0] data_im_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [N_LOG2-1:0]            bin_o,
    output logic                         last_o,
    output logic signed [DATA_WIDTH-1:0] data_re_o,
    output logic signed [DATA_WIDTH-1:0] data_im_o,
    output logic                         drop_o,
    output logic                         abort_o
);

    localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

    wr_st_t              r_wr_st, w_wr_nxt;
    rd_st_t              r_rd_st, w_rd_nxt;
    bank_st_t            r_bank_st [2];
    bank_st_t            w_bank_nxt [2];
    logic                r_wptr, w_wptr_nxt;
    logic                r_rptr, w_rptr_nxt;
    logic [N_LOG2-1:0]   r_wcnt, w_wcnt_nxt;
    logic [N_LOG2-1:0]   r_raddr, w_raddr_nxt;
    logic                r_valid, r_last, r_drop, r_abort, r_out_bank;
    logic [N_LOG2-1:0]   r_bin;

    logic                w_advance, w_issue, w_rd_done, w_tgt_free;
    logic                w_we, w_drop, w_abort;
    logic signed [DATA_WIDTH-1:0] w_rd_re [2];
    logic signed [DATA_WIDTH-1:0] w_rd_im [2];

    assign w_advance = !r_valid || ready_i;
    assign w_issue   = (r_rd_st == RD_DRAIN) && w_advance;
    assign w_rd_done = w_issue && (r_raddr == LAST);
    // A bank released by the reader on this edge may be claimed by the writer on the same edge.
    assign w_tgt_free = (r_bank_st[r_wptr] == BANK_EMPTY) || (w_rd_done && (r_rptr == r_wptr));

    always_comb begin
        w_wr_nxt    = r_wr_st;
        w_rd_nxt    = r_rd_st;
        w_bank_nxt  = r_bank_st;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_wcnt_nxt  = r_wcnt;
        w_raddr_nxt = r_raddr;
        w_we        = 1'b0;
        w_drop      = 1'b0;
        w_abort     = 1'b0;

        case (r_rd_st)
            RD_IDLE: begin
                if (r_bank_st[r_rptr] == BANK_FULL) begin
                    w_bank_nxt[r_rptr] = BANK_DRAINING;
                    w_raddr_nxt        = '0;
                    w_rd_nxt           = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (w_issue) begin
                    w_raddr_nxt = r_raddr + N_LOG2'(1);
                    if (w_rd_done) begin
                        w_bank_nxt[r_rptr] = BANK_EMPTY;
                        w_rptr_nxt         = !r_rptr;
                        // Chain straight into the other bank so the stream has no bubble.
                        if (r_bank_st[!r_rptr] == BANK_FULL) begin
                            w_bank_nxt[!r_rptr] = BANK_DRAINING;
                            w_raddr_nxt         = '0;
                        end else begin
                            w_rd_nxt = RD_IDLE;
                        end
                    end
                end
            end
            default: w_rd_nxt = RD_IDLE;
        endcase

        // Writer updates come last so a same-edge claim overrides the reader's release.
        case (r_wr_st)
            WR_IDLE: begin
                if (sync_i) begin
                    w_wcnt_nxt = N_LOG2'(1);
                    if (w_tgt_free) begin
                        w_we               = 1'b1;
                        w_bank_nxt[r_wptr] = BANK_FILLING;
                        w_wr_nxt           = WR_FILL;
                    end else begin
                        w_drop   = 1'b1;
                        w_wr_nxt = WR_DROP;
                    end
                end
            end
            WR_FILL: begin
                if (sync_i) begin
                    w_we = 1'b1;
                    if (r_wcnt == LAST) begin
                        w_bank_nxt[r_wptr] = BANK_FULL;
                        w_wptr_nxt         = !r_wptr;
                        w_wcnt_nxt         = '0;
                        w_wr_nxt           = WR_IDLE;
                    end else begin
                        w_wcnt_nxt = r_wcnt + N_LOG2'(1);
                    end
                end else begin
                    w_abort            = 1'b1;
                    w_bank_nxt[r_wptr] = BANK_EMPTY;
                    w_wcnt_nxt         = '0;
                    w_wr_nxt           = WR_IDLE;
                end
            end
            WR_DROP: begin
                if (sync_i && (r_wcnt != LAST)) begin
                    w_wcnt_nxt = r_wcnt + N_LOG2'(1);
                end else begin
                    w_wcnt_nxt = '0;
                    w_wr_nxt   = WR_IDLE;
                end
            end
            default: w_wr_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_wr_st      <= WR_IDLE;
            r_rd_st      <= RD_IDLE;
            r_bank_st[0] <= BANK_EMPTY;
            r_bank_st[1] <= BANK_EMPTY;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_wcnt       <= '0;
            r_raddr      <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_bin        <= '0;
            r_out_bank   <= 1'b0;
            r_drop       <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_wr_st   <= w_wr_nxt;
            r_rd_st   <= w_rd_nxt;
            r_bank_st <= w_bank_nxt;
            r_wptr    <= w_wptr_nxt;
            r_rptr    <= w_rptr_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_raddr   <= w_raddr_nxt;
            r_drop    <= w_drop;
            r_abort   <= w_abort;
            if (w_advance) begin
                r_valid <= w_issue;
                r_last  <= w_issue && (r_raddr == LAST);
            end
            if (w_issue) begin
                r_bin      <= r_raddr;
                r_out_bank <= r_rptr;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_r22sdf_reorder_bank #(
            .N          (N),
            .N_LOG2     (N_LOG2),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_n   (rst_n),
            .i_we    (w_we && (r_wptr == 1'(g))),
            .i_waddr (bin_i),
            .i_wre   (data_re_i),
            .i_wim   (data_im_i),
            .i_re    (w_issue && (r_rptr == 1'(g))),
            .i_raddr (r_raddr),
            .o_re    (w_rd_re[g]),
            .o_im    (w_rd_im[g])
        );
    end

    assign valid_o   = r_valid;
    assign bin_o     = r_bin;
    assign last_o    = r_last;
    assign data_re_o = w_rd_re[r_out_bank];
    assign data_im_o = w_rd_im[r_out_bank];
    assign drop_o    = r_drop;
    assign abort_o   = r_abort;

endmodule

// File: tb/tb_fft_r22sdf_reorder.sv
// Directed bench for the reorder buffer at N=16: ramp, back-to-back, random stall,
// overflow drop, mid-frame abort and mid-drain reset.
module tb_fft_r22sdf_reorder;

    localparam int N  = 16;
    localparam int NL = 4;
    localparam int DW = 25;

    logic                 clk_i = 1'b0;
    logic                 rst_n;
    logic                 sync_i;
    logic [NL-1:0]        bin_i;
    logic signed [DW-1:0] data_re_i;
    logic signed [DW-1:0] data_im_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [NL-1:0]        bin_o;
    logic                 last_o;
    logic signed [DW-1:0] data_re_o;
    logic signed [DW-1:0] data_im_o;
    logic                 drop_o;
    logic                 abort_o;

    always #5 clk_i = ~clk_i;

    fft_r22sdf_reorder #(.N(N), .N_LOG2(NL), .DATA_WIDTH(DW)) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .sync_i    (sync_i),
        .bin_i     (bin_i),
        .data_re_i (data_re_i),
        .data_im_i (data_im_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .bin_o     (bin_o),
        .last_o    (last_o),
        .data_re_o (data_re_o),
        .data_im_o (data_im_o),
        .drop_o    (drop_o),
        .abort_o   (abort_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_frames[$];
    int exp_bin    = 0;
    bit mon_en     = 1'b0;
    int run_len    = 0;
    int max_run    = 0;
    int n_drop     = 0;
    int ready_mode = 1;   // 0: low, 1: high, 2: random
    bit prev_stall = 1'b0;
    int prev_bin, prev_re, prev_im, m_fid, d0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int x);
        int r = 0;
        for (int k = 0; k < NL; k++)
            if (x[k]) r |= (1 << (NL - 1 - k));
        return r;
    endfunction

    function automatic int exp_re(input int fid, input int b);
        return fid * N + b;
    endfunction

    function automatic int exp_im(input int fid, input int b);
        return -(fid * N + b) - 1;
    endfunction

    task automatic drive_ready();
        case (ready_mode)
            0:       ready_i = 1'b0;
            1:       ready_i = 1'b1;
            default: ready_i = ($urandom_range(0, 1) != 0);
        endcase
    endtask

    task automatic send_frame(input int fid, input int nsamp, input bit exp_drop);
        for (int i = 0; i < nsamp; i++) begin
            @(posedge clk_i); #1;
            sync_i    = 1'b1;
            bin_i     = NL'(bitrev(i));
            data_re_i = DW'(exp_re(fid, bitrev(i)));
            data_im_i = DW'(exp_im(fid, bitrev(i)));
            drive_ready();
            if (i == 1) begin
                @(negedge clk_i);
                chk($sformatf("drop_f%0d", fid), int'(drop_o), int'(exp_drop));
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            sync_i = 1'b0;
            drive_ready();
        end
    endtask

    task automatic wait_empty(input string tag);
        int k = 0;
        while (exp_frames.size() != 0 && k < 300) begin
            idle(1);
            k++;
        end
        idle(3);
        chk(tag, exp_frames.size(), 0);
    endtask

    // Output scoreboard: natural order per frame, and AXI-style hold while stalled.
    always @(negedge clk_i) begin
        if (rst_n && mon_en) begin
            run_len = valid_o ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (drop_o) n_drop++;
            if (prev_stall) begin
                chk("hold_vld", int'(valid_o), 1);
                chk("hold_bin", int'(bin_o), prev_bin);
                chk("hold_re", int'(data_re_o), prev_re);
                chk("hold_im", int'(data_im_o), prev_im);
            end
            if (valid_o && ready_i) begin
                if (exp_frames.size() == 0) begin
                    chk("unexpected_sample_bin", int'(bin_o), -1);
                end else begin
                    m_fid = exp_frames[0];
                    chk($sformatf("bin_f%0d", m_fid), int'(bin_o), exp_bin);
                    chk($sformatf("re_f%0d", m_fid), int'(data_re_o), exp_re(m_fid, exp_bin));
                    chk($sformatf("im_f%0d", m_fid), int'(data_im_o), exp_im(m_fid, exp_bin));
                    chk($sformatf("last_f%0d", m_fid), int'(last_o), int'(exp_bin == N - 1));
                    if (exp_bin == N - 1) begin
                        exp_bin = 0;
                        void'(exp_frames.pop_front());
                    end else begin
                        exp_bin++;
                    end
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_bin   = int'(bin_o);
            prev_re    = int'(data_re_o);
            prev_im    = int'(data_im_o);
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sync_i = 1'b0; bin_i = '0;
        data_re_i = '0; data_im_i = '0; ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b1;
        @(negedge clk_i);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_last", int'(last_o), 0);
        chk("rst_bin", int'(bin_o), 0);
        chk("rst_re", int'(data_re_o), 0);
        chk("rst_im", int'(data_im_o), 0);
        chk("rst_drop", int'(drop_o), 0);
        chk("rst_abort", int'(abort_o), 0);
        mon_en = 1'b1;

        // Ramp and first-output latency
        exp_frames.push_back(0);
        send_frame(0, N, 1'b0);
        idle(1);
        @(negedge clk_i); chk("lat_t0_valid", int'(valid_o), 0);
        idle(1);
        @(negedge clk_i); chk("lat_t1_valid", int'(valid_o), 0);
        idle(1);
        @(negedge clk_i); chk("lat_t2_valid", int'(valid_o), 1);
        chk("lat_t2_bin", int'(bin_o), 0);
        wait_empty("ramp_drain");

        // Four frames back-to-back
        d0 = n_drop; max_run = 0;
        for (int f = 1; f <= 4; f++) exp_frames.push_back(f);
        for (int f = 1; f <= 4; f++) send_frame(f, N, 1'b0);
        wait_empty("b2b_drain");
        chk("b2b_run", max_run, 4 * N);
        chk("b2b_drops", n_drop - d0, 0);

        // Random backpressure
        ready_mode = 2; d0 = n_drop;
        exp_frames.push_back(5); exp_frames.push_back(6);
        send_frame(5, N, 1'b0);
        send_frame(6, N, 1'b0);
        wait_empty("rnd_drain");
        chk("rnd_drops", n_drop - d0, 0);
        ready_mode = 1;

        // Stalled consumer: third frame has no free bank
        ready_mode = 0; d0 = n_drop;
        exp_frames.push_back(7); exp_frames.push_back(8);
        send_frame(7, N, 1'b0);
        send_frame(8, N, 1'b0);
        send_frame(9, N, 1'b1);
        idle(5);
        ready_mode = 1;
        wait_empty("stall_drain");
        chk("stall_drops", n_drop - d0, 1);

        // Mid-frame abort, then a clean frame
        send_frame(10, 7, 1'b0);
        idle(1);
        @(posedge clk_i);
        @(negedge clk_i); chk("abort_pulse", int'(abort_o), 1);
        @(negedge clk_i); chk("abort_clear", int'(abort_o), 0);
        exp_frames.push_back(11);
        send_frame(11, N, 1'b0);
        wait_empty("post_abort_drain");

        // Reset mid-drain, then a clean frame
        mon_en = 1'b0;
        send_frame(12, N, 1'b0);
        idle(8);
        rst_n = 1'b0;
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_valid", int'(valid_o), 0);
        chk("mid_rst_last", int'(last_o), 0);
        exp_bin = 0;
        exp_frames.delete();
        mon_en = 1'b1;
        exp_frames.push_back(13);
        send_frame(13, N, 1'b0);
        wait_empty("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
